// File: rtl/decode_arb_pkg.sv
// Shared definitions for the decode-to-issue arbiter slice.
// Payload field layout, from MSB to LSB: opcode, addr, funcUnit, majId, minId, is64, pid, tid, body.
package decode_arb_pkg;

    localparam int PAYLOAD_W = 215;

    localparam int BODY_LSB  = 0;
    localparam int BODY_W    = 28;
    localparam int TID_LSB   = 28;
    localparam int TID_W     = 16;
    localparam int PID_LSB   = 44;
    localparam int PID_W     = 20;
    localparam int IS64_LSB  = 64;
    localparam int MINID_LSB = 65;
    localparam int MINID_W   = 7;
    localparam int MAJID_LSB = 72;
    localparam int MAJID_W   = 64;
    localparam int FU_LSB    = 136;
    localparam int FU_W      = 3;
    localparam int ADDR_LSB  = 139;
    localparam int ADDR_W    = 64;
    localparam int OPC_LSB   = 203;
    localparam int OPC_W     = 12;

    typedef enum logic [2:0] {
        FU_FX = 3'd0,
        FU_FP = 3'd1,
        FU_VX = 3'd2,
        FU_CR = 3'd3,
        FU_LS = 3'd4,
        FU_BR = 3'd6
    } func_unit_e;

    function automatic logic [MAJID_W-1:0] get_maj_id(
        input logic [PAYLOAD_W-1:0] p
    );
        return p[MAJID_LSB +: MAJID_W];
    endfunction

endpackage

// File: rtl/decode_lane_fifo.sv
// Per-lane synchronous FIFO with flush.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module decode_lane_fifo
    import decode_arb_pkg::*;
#(
    parameter int depth = 4,
    parameter int width = PAYLOAD_W
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           wdata,
    output logic [width-1:0]           rdata,
    output logic [$clog2(depth):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wrPtr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at depth.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rdPtr];
    assign full  = (count == CNT_W'(depth));
    assign empty = (count == '0);

endmodule

// File: rtl/decode_issue_arbiter.sv
// Buffers decoded instructions per lane and round-robin issues them
// through a single registered port toward dispatch.
module decode_issue_arbiter
    import decode_arb_pkg::*;
#(
    parameter int numLanes     = 2,
    parameter int fifoDepth    = 4,
    parameter int payloadWidth = PAYLOAD_W,
    parameter int laneIdWidth  = 3
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             flush_i,
    input  logic [numLanes-1:0]              laneValid_i,
    input  logic [numLanes*payloadWidth-1:0] lanePayload_i,
    output logic [numLanes-1:0]              laneStall_o,
    output logic                             issueValid_o,
    output logic [payloadWidth-1:0]          issuePayload_o,
    output logic [laneIdWidth-1:0]           issueLane_o,
    input  logic                             issueStall_i,
    output logic                             overflow_o
);

    localparam int CNT_W = $clog2(fifoDepth) + 1;

    logic [numLanes-1:0]     push;
    logic [numLanes-1:0]     pop;
    logic [numLanes-1:0]     full;
    logic [numLanes-1:0]     empty;
    logic [payloadWidth-1:0] headData  [numLanes];
    logic [CNT_W-1:0]        laneCount [numLanes];

    logic                    load;
    logic                    grantValid;
    logic [laneIdWidth-1:0]  grantLane;
    logic [laneIdWidth-1:0]  rrPtr;
    logic                    overflowSet;

    for (genvar g = 0; g < numLanes; g++) begin : g_lane
        decode_lane_fifo #(
            .depth (fifoDepth),
            .width (payloadWidth)
        ) u_fifo (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .flush_i (flush_i),
            .push    (push[g]),
            .pop     (pop[g]),
            .wdata   (lanePayload_i[g*payloadWidth +: payloadWidth]),
            .rdata   (headData[g]),
            .count   (laneCount[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );

        // Two entries of slack absorb the decoder's in-flight output.
        assign laneStall_o[g] = (laneCount[g] >= CNT_W'(fifoDepth - 2));
    end

    assign load = !issueValid_o || !issueStall_i;

    // Round-robin search starting one past the last granted lane.
    always_comb begin
        int idx;
        grantValid = 1'b0;
        grantLane  = '0;
        idx        = 0;
        for (int i = 0; i < numLanes; i++) begin
            idx = int'(rrPtr) + 1 + i;
            if (idx >= numLanes) begin
                idx = idx - numLanes;
            end
            if (!grantValid && !empty[idx]) begin
                grantValid = 1'b1;
                grantLane  = laneIdWidth'(idx);
            end
        end
    end

    // Pop the granted head; accept pushes when space exists or a pop frees it.
    always_comb begin
        pop         = '0;
        push        = '0;
        overflowSet = 1'b0;
        for (int k = 0; k < numLanes; k++) begin
            pop[k]  = load && grantValid && !flush_i &&
                      (grantLane == laneIdWidth'(k));
            push[k] = laneValid_i[k] && !flush_i && (!full[k] || pop[k]);
            if (laneValid_i[k] && !flush_i && full[k] && !pop[k]) begin
                overflowSet = 1'b1;
            end
        end
    end

    // Issue register and round-robin pointer.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            issueValid_o   <= 1'b0;
            issuePayload_o <= '0;
            issueLane_o    <= '0;
            rrPtr          <= laneIdWidth'(numLanes - 1);
        end else if (flush_i) begin
            issueValid_o   <= 1'b0;
        end else if (load) begin
            if (grantValid) begin
                issueValid_o   <= 1'b1;
                issuePayload_o <= headData[grantLane];
                issueLane_o    <= grantLane;
                rrPtr          <= grantLane;
            end else begin
                issueValid_o   <= 1'b0;
            end
        end
    end

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            overflow_o <= 1'b0;
        end else if (overflowSet) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_issue_arbiter.sv
// Directed self-checking bench for decode_issue_arbiter.
// Default parameters: two lanes, depth-4 FIFOs.
module tb_decode_issue_arbiter;
    import decode_arb_pkg::*;

    localparam int NL = 2;
    localparam int PW = PAYLOAD_W;

    logic              clock_i;
    logic              reset_i;
    logic              flush_i;
    logic [NL-1:0]     laneValid_i;
    logic [NL*PW-1:0]  lanePayload_i;
    logic [NL-1:0]     laneStall_o;
    logic              issueValid_o;
    logic [PW-1:0]     issuePayload_o;
    logic [2:0]        issueLane_o;
    logic              issueStall_i;
    logic              overflow_o;

    int total;
    int fails;

    decode_issue_arbiter dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .flush_i        (flush_i),
        .laneValid_i    (laneValid_i),
        .lanePayload_i  (lanePayload_i),
        .laneStall_o    (laneStall_o),
        .issueValid_o   (issueValid_o),
        .issuePayload_o (issuePayload_o),
        .issueLane_o    (issueLane_o),
        .issueStall_i   (issueStall_i),
        .overflow_o     (overflow_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_maj(input int k, input logic [63:0] maj);
        lanePayload_i[k*PW +: PW] = '0;
        lanePayload_i[k*PW + MAJID_LSB +: 64] = maj;
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        flush_i      = 1'b0;
        laneValid_i  = '0;
        issueStall_i = 1'b0;
        tick();
        reset_i = 1'b0;
    endtask

    function automatic logic [63:0] maj_out();
        return issuePayload_o[MAJID_LSB +: 64];
    endfunction

    logic [63:0] expMaj  [6];
    logic [2:0]  expLane [6];

    initial begin
        total         = 0;
        fails         = 0;
        lanePayload_i = '0;
        do_reset();
        do_reset();

        // Reset state
        chk("rst_valid", 64'(issueValid_o), 64'd0);
        chk("rst_payload", 64'(issuePayload_o == '0), 64'd1);
        chk("rst_lane", 64'(issueLane_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_stall", 64'(laneStall_o), 64'd0);

        // Single push: visible after second edge, gone after third
        laneValid_i = 2'b01;
        set_maj(0, 64'h10);
        tick();
        laneValid_i = '0;
        chk("single_nobypass", 64'(issueValid_o), 64'd0);
        tick();
        chk("single_valid", 64'(issueValid_o), 64'd1);
        chk("single_lane", 64'(issueLane_o), 64'd0);
        chk("single_maj", maj_out(), 64'h10);
        tick();
        chk("single_drain", 64'(issueValid_o), 64'd0);

        // Round robin across two lanes
        do_reset();
        expMaj  = '{64'h20, 64'h30, 64'h21, 64'h31, 64'h22, 64'h32};
        expLane = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
        for (int j = 0; j < 7; j++) begin
            if (j < 3) begin
                laneValid_i = 2'b11;
                set_maj(0, 64'h20 + 64'(j));
                set_maj(1, 64'h30 + 64'(j));
            end else begin
                laneValid_i = '0;
            end
            tick();
            if (j >= 1) begin
                chk($sformatf("rr_lane%0d", j - 1), 64'(issueLane_o),
                    64'(expLane[j-1]));
                chk($sformatf("rr_maj%0d", j - 1), maj_out(), expMaj[j-1]);
            end
        end
        tick();
        chk("rr_drain", 64'(issueValid_o), 64'd0);

        // Backpressure: five pushes on lane 0 while dispatch stalls
        do_reset();
        issueStall_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            laneValid_i = (j < 5) ? 2'b01 : 2'b00;
            set_maj(0, 64'h40 + 64'(j));
            tick();
            if (j == 1) chk("bp_stall_c1", 64'(laneStall_o[0]), 64'd0);
            if (j == 2) chk("bp_stall_c2", 64'(laneStall_o[0]), 64'd1);
            if (j == 4) chk("bp_ovf", 64'(overflow_o), 64'd0);
        end
        chk("bp_hold_valid", 64'(issueValid_o), 64'd1);
        chk("bp_hold_maj", maj_out(), 64'h40);
        issueStall_i = 1'b0;
        for (int j = 1; j < 5; j++) begin
            tick();
            chk($sformatf("bp_drain_maj%0d", j), maj_out(), 64'h40 + 64'(j));
            chk($sformatf("bp_drain_v%0d", j), 64'(issueValid_o), 64'd1);
        end
        tick();
        chk("bp_empty", 64'(issueValid_o), 64'd0);
        chk("bp_stall_clear", 64'(laneStall_o), 64'd0);

        // Overflow on lane 1 while the issue register is occupied
        do_reset();
        issueStall_i = 1'b1;
        laneValid_i  = 2'b01;
        set_maj(0, 64'h60);
        tick();
        laneValid_i = '0;
        tick();
        for (int j = 0; j < 5; j++) begin
            laneValid_i = 2'b10;
            set_maj(1, 64'h50 + 64'(j));
            tick();
            if (j == 3) chk("ovf_before", 64'(overflow_o), 64'd0);
        end
        laneValid_i = '0;
        chk("ovf_set", 64'(overflow_o), 64'd1);
        chk("ovf_held_maj", maj_out(), 64'h60);
        issueStall_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("ovf_lane%0d", j), 64'(issueLane_o), 64'd1);
            chk($sformatf("ovf_maj%0d", j), maj_out(), 64'h50 + 64'(j));
        end
        tick();
        chk("ovf_dropped", 64'(issueValid_o), 64'd0);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);
        do_reset();
        chk("ovf_reset", 64'(overflow_o), 64'd0);

        // Flush mid-stream with lanes holding 3 + 2 entries
        issueStall_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            laneValid_i = (j < 2) ? 2'b11 : 2'b01;
            set_maj(0, 64'h70 + 64'(j));
            set_maj(1, 64'h80 + 64'(j));
            tick();
        end
        chk("fl_pre_valid", 64'(issueValid_o), 64'd1);
        chk("fl_pre_stall", 64'(laneStall_o), 64'b11);
        flush_i     = 1'b1;
        laneValid_i = 2'b01;
        set_maj(0, 64'h77);
        tick();
        flush_i      = 1'b0;
        laneValid_i  = '0;
        issueStall_i = 1'b0;
        chk("fl_valid", 64'(issueValid_o), 64'd0);
        chk("fl_stall", 64'(laneStall_o), 64'd0);
        tick();
        chk("fl_not_stored", 64'(issueValid_o), 64'd0);
        laneValid_i = 2'b01;
        set_maj(0, 64'h88);
        tick();
        laneValid_i = '0;
        chk("fl_new_lat", 64'(issueValid_o), 64'd0);
        tick();
        chk("fl_new_valid", 64'(issueValid_o), 64'd1);
        chk("fl_new_maj", maj_out(), 64'h88);
        chk("fl_new_lane", 64'(issueLane_o), 64'd0);

        // Reset with both FIFOs full and dispatch stalled
        issueStall_i = 1'b1;
        laneValid_i  = 2'b11;
        for (int j = 0; j < 6; j++) begin
            set_maj(0, 64'h90 + 64'(j));
            set_maj(1, 64'hA0 + 64'(j));
            tick();
        end
        chk("mr_pre_stall", 64'(laneStall_o), 64'b11);
        chk("mr_pre_ovf", 64'(overflow_o), 64'd1);
        reset_i = 1'b1;
        tick();
        chk("mr_valid", 64'(issueValid_o), 64'd0);
        chk("mr_payload", 64'(issuePayload_o == '0), 64'd1);
        chk("mr_lane", 64'(issueLane_o), 64'd0);
        chk("mr_stall", 64'(laneStall_o), 64'd0);
        chk("mr_ovf", 64'(overflow_o), 64'd0);
        reset_i     = 1'b0;
        laneValid_i = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 total, fails);
        $finish;
    end

endmodule
